// File: rtl/uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// uart_cmd_responder
//
// Host-side command responder for a UART receive/transmit FIFO pair. It pops
// command bytes from the receive FIFO, decodes a small binary register-access
// protocol, runs 8-bit accesses on a local register bus and pushes exactly one
// reply byte per command into the transmit FIFO.
//
//   'W' addr data -> register write, reply 'K' (0x4B)
//   'R' addr      -> register read,  reply = read byte
//   other byte    -> reply '?' (0x3F)
//
// Optional feature, enabled by defining UART_CMD_STATUS_EN:
//   a saturating 8-bit error counter (unknown opcodes and frame timeouts);
//   opcode 'S' (0x53) replies with the counter value and clears it.
//   Without the macro, 'S' is just another unknown opcode.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles tolerated between bytes of one frame (>= 2)
//   READ_LATENCY    cycles from reg_re to valid reg_rdata (1..4)
//
// Ports:
//   clk                  system clock
//   reset                synchronous, active-low reset
//   receive_data[7:0]    head byte of the receive FIFO
//   receive_data_preset  receive FIFO non-empty
//   buffer_read          one-cycle pop of the receive FIFO
//   transmit_data[7:0]   reply byte for the transmit FIFO
//   buffer_write         one-cycle push into the transmit FIFO
//   transmit_full        transmit FIFO full
//   reg_addr[7:0]        register bus address
//   reg_wdata[7:0]       register bus write data
//   reg_we               one-cycle write strobe
//   reg_re               one-cycle read strobe
//   reg_rdata[7:0]       register read data
//   busy                 high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_cmd_responder #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int READ_LATENCY   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] receive_data,
  input  logic       receive_data_preset,
  output logic       buffer_read,
  output logic [7:0] transmit_data,
  output logic       buffer_write,
  input  logic       transmit_full,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]      RD_LAST   = 3'(READ_LATENCY);

  localparam logic [7:0] OP_WRITE  = 8'h57;
  localparam logic [7:0] OP_READ   = 8'h52;
  localparam logic [7:0] RPL_OK    = 8'h4B;
  localparam logic [7:0] RPL_ERR   = 8'h3F;
`ifdef UART_CMD_STATUS_EN
  localparam logic [7:0] OP_STATUS = 8'h53;
`endif

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    DO_WRITE,
    DO_READ,
    READ_WAIT,
    SEND
  } state_t;

  state_t          state_reg, state_next;
  logic            skip_reg, skip_next;
  logic            is_write_reg, is_write_next;
  logic [7:0]      reg_addr_reg, reg_addr_next;
  logic [7:0]      reg_wdata_reg, reg_wdata_next;
  logic [7:0]      reply_reg, reply_next;
  logic [TO_W-1:0] timeout_cnt_reg, timeout_cnt_next;
  logic [2:0]      rd_cnt_reg, rd_cnt_next;
  logic            buffer_read_reg, buffer_read_next;
  logic            buffer_write_reg, buffer_write_next;
  logic [7:0]      transmit_data_reg, transmit_data_next;
  logic            reg_we_reg, reg_we_next;
  logic            reg_re_reg, reg_re_next;
  logic            busy_reg, busy_next;

  // A byte is taken only when the FIFO is non-empty and we are not in the
  // settle cycle that follows a pop. buffer_read is registered, so the FIFO
  // head only advances one cycle after we latched it; skipping one cycle
  // keeps us from seeing the same byte twice.
  logic            accept;
  logic [TO_W-1:0] to_inc;

`ifdef UART_CMD_STATUS_EN
  logic [7:0] err_cnt_reg, err_cnt_next;
  logic       err_evt;
  logic       err_clr;
`endif

  assign accept = receive_data_preset && !skip_reg;
  // Saturating increment; the counter never wraps back to zero.
  assign to_inc = (timeout_cnt_reg == TO_LIMIT) ? timeout_cnt_reg
                                                : timeout_cnt_reg + TO_W'(1);

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next         = state_reg;
    skip_next          = 1'b0;
    is_write_next      = is_write_reg;
    reg_addr_next      = reg_addr_reg;
    reg_wdata_next     = reg_wdata_reg;
    reply_next         = reply_reg;
    timeout_cnt_next   = '0;
    rd_cnt_next        = '0;
    buffer_read_next   = 1'b0;
    buffer_write_next  = 1'b0;
    transmit_data_next = transmit_data_reg;
    reg_we_next        = 1'b0;
    reg_re_next        = 1'b0;
`ifdef UART_CMD_STATUS_EN
    err_evt            = 1'b0;
    err_clr            = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          buffer_read_next = 1'b1;
          skip_next        = 1'b1;
          if ((receive_data == OP_WRITE) || (receive_data == OP_READ)) begin
            is_write_next = (receive_data == OP_WRITE);
            state_next    = GET_ADDR;
`ifdef UART_CMD_STATUS_EN
          end else if (receive_data == OP_STATUS) begin
            reply_next = err_cnt_reg;
            err_clr    = 1'b1;
            state_next = SEND;
`endif
          end else begin
            reply_next = RPL_ERR;
            state_next = SEND;
`ifdef UART_CMD_STATUS_EN
            err_evt    = 1'b1;
`endif
          end
        end
      end

      GET_ADDR, GET_DATA: begin
        if (accept) begin
          buffer_read_next = 1'b1;
          skip_next        = 1'b1;
          if (state_reg == GET_ADDR) begin
            reg_addr_next = receive_data;
            state_next    = is_write_reg ? GET_DATA : DO_READ;
          end else begin
            reg_wdata_next = receive_data;
            state_next     = DO_WRITE;
          end
        end else if (!receive_data_preset) begin
          // Idle line: count toward abandoning the partial frame.
          timeout_cnt_next = to_inc;
          if (to_inc == TO_LIMIT) begin
            state_next       = IDLE;
            timeout_cnt_next = '0;
`ifdef UART_CMD_STATUS_EN
            err_evt          = 1'b1;
`endif
          end
        end else begin
          // Settle cycle with a byte still at the head: hold the count.
          timeout_cnt_next = timeout_cnt_reg;
        end
      end

      DO_WRITE: begin
        if (!skip_reg) begin
          reg_we_next = 1'b1;
          reply_next  = RPL_OK;
          state_next  = SEND;
        end
      end

      DO_READ: begin
        if (!skip_reg) begin
          reg_re_next = 1'b1;
          state_next  = READ_WAIT;
        end
      end

      READ_WAIT: begin
        // Entered together with the reg_re pulse; the data is valid in the
        // READ_LATENCY-th cycle after it and is captured at the end of that
        // cycle.
        if (rd_cnt_reg == RD_LAST) begin
          reply_next = reg_rdata;
          state_next = SEND;
        end else begin
          rd_cnt_next = rd_cnt_reg + 3'd1;
        end
      end

      SEND: begin
        if (!skip_reg && !transmit_full) begin
          transmit_data_next = reply_reg;
          buffer_write_next  = 1'b1;
          state_next         = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

`ifdef UART_CMD_STATUS_EN
  // An error coinciding with a clear leaves exactly that one error counted.
  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_evt) begin
      if (err_clr) begin
        err_cnt_next = 8'd1;
      end else if (err_cnt_reg != 8'hFF) begin
        err_cnt_next = err_cnt_reg + 8'd1;
      end
    end else if (err_clr) begin
      err_cnt_next = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_reg <= 8'd0;
    end else begin
      err_cnt_reg <= err_cnt_next;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg         <= IDLE;
      skip_reg          <= 1'b0;
      is_write_reg      <= 1'b0;
      reg_addr_reg      <= 8'd0;
      reg_wdata_reg     <= 8'd0;
      reply_reg         <= 8'd0;
      timeout_cnt_reg   <= '0;
      rd_cnt_reg        <= 3'd0;
      buffer_read_reg   <= 1'b0;
      buffer_write_reg  <= 1'b0;
      transmit_data_reg <= 8'd0;
      reg_we_reg        <= 1'b0;
      reg_re_reg        <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      skip_reg          <= skip_next;
      is_write_reg      <= is_write_next;
      reg_addr_reg      <= reg_addr_next;
      reg_wdata_reg     <= reg_wdata_next;
      reply_reg         <= reply_next;
      timeout_cnt_reg   <= timeout_cnt_next;
      rd_cnt_reg        <= rd_cnt_next;
      buffer_read_reg   <= buffer_read_next;
      buffer_write_reg  <= buffer_write_next;
      transmit_data_reg <= transmit_data_next;
      reg_we_reg        <= reg_we_next;
      reg_re_reg        <= reg_re_next;
      busy_reg          <= busy_next;
    end
  end

  assign buffer_read   = buffer_read_reg;
  assign buffer_write  = buffer_write_reg;
  assign transmit_data = transmit_data_reg;
  assign reg_addr      = reg_addr_reg;
  assign reg_wdata     = reg_wdata_reg;
  assign reg_we        = reg_we_reg;
  assign reg_re        = reg_re_reg;
  assign busy          = busy_reg;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_responder
//
// Scoreboard bench for uart_cmd_responder. Two instances: u_dut_a with
// READ_LATENCY=1 runs the full directed sequence; u_dut_b with
// READ_LATENCY=3 runs read frames only. Stimulus pushes bytes into a modelled
// receive FIFO and the expected replies / bus accesses into queues; negedge
// monitors pop and compare whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_uart_cmd_responder;

  localparam int TO_CYC = 50;

  logic       clk;
  logic       reset;

  // instance A (READ_LATENCY = 1)
  logic [7:0] receive_data;
  logic       receive_data_preset;
  logic       buffer_read;
  logic [7:0] transmit_data;
  logic       buffer_write;
  logic       transmit_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  // instance B (READ_LATENCY = 3)
  logic [7:0] receive_data_b;
  logic       receive_data_preset_b;
  logic       buffer_read_b;
  logic [7:0] transmit_data_b;
  logic       buffer_write_b;
  logic       transmit_full_b;
  logic [7:0] reg_addr_b;
  logic [7:0] reg_wdata_b;
  logic       reg_we_b;
  logic       reg_re_b;
  logic [7:0] reg_rdata_b;
  logic       busy_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0]  rxq_a[$];
  logic [7:0]  rxq_b[$];
  logic [7:0]  exp_tx_a[$];
  logic [15:0] exp_wr_a[$];
  logic [7:0]  exp_rd_a[$];
  logic [7:0]  exp_tx_b[$];
  logic [7:0]  exp_rd_b[$];

  logic [7:0] regs [256];
  logic [7:0] pipe_b [3];

  int   bw_count     = 0;
  int   last_pop_cyc = 0;
  int   we_cyc       = 0;
  bit   we_pending   = 0;
  logic prev_br      = 1'b0;
  logic prev_br_b    = 1'b0;

  uart_cmd_responder #(.TIMEOUT_CYCLES(TO_CYC), .READ_LATENCY(1)) u_dut_a (
    .clk                 (clk),
    .reset               (reset),
    .receive_data        (receive_data),
    .receive_data_preset (receive_data_preset),
    .buffer_read         (buffer_read),
    .transmit_data       (transmit_data),
    .buffer_write        (buffer_write),
    .transmit_full       (transmit_full),
    .reg_addr            (reg_addr),
    .reg_wdata           (reg_wdata),
    .reg_we              (reg_we),
    .reg_re              (reg_re),
    .reg_rdata           (reg_rdata),
    .busy                (busy)
  );

  uart_cmd_responder #(.TIMEOUT_CYCLES(TO_CYC), .READ_LATENCY(3)) u_dut_b (
    .clk                 (clk),
    .reset               (reset),
    .receive_data        (receive_data_b),
    .receive_data_preset (receive_data_preset_b),
    .buffer_read         (buffer_read_b),
    .transmit_data       (transmit_data_b),
    .buffer_write        (buffer_write_b),
    .transmit_full       (transmit_full_b),
    .reg_addr            (reg_addr_b),
    .reg_wdata           (reg_wdata_b),
    .reg_we              (reg_we_b),
    .reg_re              (reg_re_b),
    .reg_rdata           (reg_rdata_b),
    .busy                (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- register bus slave models ----------------
  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    regs[8'h22] = 8'h3C;
    regs[8'h01] = 8'hC3;
    reg_rdata   = 8'hEE;
    for (int i = 0; i < 3; i++) pipe_b[i] = 8'hEE;
  end

  // Read data is valid only in the single cycle READ_LATENCY after reg_re.
  always @(posedge clk) begin
    if (reg_we) regs[reg_addr] <= reg_wdata;
    reg_rdata <= reg_re ? regs[reg_addr] : 8'hEE;
    pipe_b[0] <= reg_re_b ? regs[reg_addr_b] : 8'hEE;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign reg_rdata_b = pipe_b[2];

  // ---------------- receive FIFO models ----------------
  initial begin
    receive_data          = 8'h00;
    receive_data_preset   = 1'b0;
    receive_data_b        = 8'h00;
    receive_data_preset_b = 1'b0;
  end

  always @(negedge clk) begin
    if (buffer_read && rxq_a.size() > 0) void'(rxq_a.pop_front());
    receive_data_preset = (rxq_a.size() > 0);
    receive_data        = (rxq_a.size() > 0) ? rxq_a[0] : 8'h00;
    if (buffer_read_b && rxq_b.size() > 0) void'(rxq_b.pop_front());
    receive_data_preset_b = (rxq_b.size() > 0);
    receive_data_b        = (rxq_b.size() > 0) ? rxq_b[0] : 8'h00;
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (buffer_read) begin
      chk("rx_pop_not_adjacent", {31'd0, prev_br}, 32'd0);
      last_pop_cyc = cyc;
    end
    prev_br = buffer_read;

    if (reg_we) begin
      chk("we_re_exclusive", {31'd0, reg_re}, 32'd0);
      chk("we_latency_from_pop", cyc - last_pop_cyc, 32'd2);
      we_cyc     = cyc;
      we_pending = 1;
      if (exp_wr_a.size() == 0) begin
        chk("unexpected_reg_we", {16'd0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
      end else begin
        chk("reg_write_addr_data", {16'd0, reg_addr, reg_wdata}, {16'd0, exp_wr_a.pop_front()});
      end
      $display("A write addr=%02h data=%02h", reg_addr, reg_wdata);
    end

    if (reg_re) begin
      if (exp_rd_a.size() == 0) begin
        chk("unexpected_reg_re", {24'd0, reg_addr}, 32'hFFFF_FFFF);
      end else begin
        chk("reg_read_addr", {24'd0, reg_addr}, {24'd0, exp_rd_a.pop_front()});
      end
      $display("A read addr=%02h", reg_addr);
    end

    if (buffer_write) begin
      bw_count++;
      if (we_pending) begin
        chk("reply_latency_after_we", cyc - we_cyc, 32'd1);
        we_pending = 0;
      end
      if (exp_tx_a.size() == 0) begin
        chk("unexpected_reply", {24'd0, transmit_data}, 32'hFFFF_FFFF);
      end else begin
        chk("reply_byte", {24'd0, transmit_data}, {24'd0, exp_tx_a.pop_front()});
      end
      $display("A reply %02h", transmit_data);
    end
  end

  always @(negedge clk) begin
    if (buffer_read_b) begin
      chk("b_rx_pop_not_adjacent", {31'd0, prev_br_b}, 32'd0);
    end
    prev_br_b = buffer_read_b;
    if (reg_we_b) begin
      chk("b_unexpected_reg_we", {24'd0, reg_addr_b}, 32'hFFFF_FFFF);
    end
    if (reg_re_b) begin
      if (exp_rd_b.size() == 0) begin
        chk("b_unexpected_reg_re", {24'd0, reg_addr_b}, 32'hFFFF_FFFF);
      end else begin
        chk("b_reg_read_addr", {24'd0, reg_addr_b}, {24'd0, exp_rd_b.pop_front()});
      end
      $display("B read addr=%02h", reg_addr_b);
    end
    if (buffer_write_b) begin
      if (exp_tx_b.size() == 0) begin
        chk("b_unexpected_reply", {24'd0, transmit_data_b}, 32'hFFFF_FFFF);
      end else begin
        chk("b_reply_byte", {24'd0, transmit_data_b}, {24'd0, exp_tx_b.pop_front()});
      end
      $display("B reply %02h", transmit_data_b);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((rxq_a.size() != 0 || busy || exp_tx_a.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("a_idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while ((rxq_b.size() != 0 || busy_b || exp_tx_b.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("b_idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_buffer_read",   {31'd0, buffer_read},   32'd0);
    chk("rst_buffer_write",  {31'd0, buffer_write},  32'd0);
    chk("rst_reg_we",        {31'd0, reg_we},        32'd0);
    chk("rst_reg_re",        {31'd0, reg_re},        32'd0);
    chk("rst_busy",          {31'd0, busy},          32'd0);
    chk("rst_reg_addr",      {24'd0, reg_addr},      32'd0);
    chk("rst_reg_wdata",     {24'd0, reg_wdata},     32'd0);
    chk("rst_transmit_data", {24'd0, transmit_data}, 32'd0);
    chk("rst_b_busy",        {31'd0, busy_b},        32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int bw0;

  initial begin
    reset           = 1'b0;
    transmit_full   = 1'b0;
    transmit_full_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero();
    step();
    reset = 1'b1;
    step();

    // register write
    rxq_a.push_back(8'h57); rxq_a.push_back(8'h10); rxq_a.push_back(8'hA5);
    exp_wr_a.push_back(16'h10A5);
    exp_tx_a.push_back(8'h4B);
    wait_idle_a();

    // register read, latency 1
    step();
    rxq_a.push_back(8'h52); rxq_a.push_back(8'h22);
    exp_rd_a.push_back(8'h22);
    exp_tx_a.push_back(8'h3C);
    wait_idle_a();

    // register reads, latency 3
    step();
    rxq_b.push_back(8'h52); rxq_b.push_back(8'h22);
    rxq_b.push_back(8'h52); rxq_b.push_back(8'h01);
    exp_rd_b.push_back(8'h22); exp_tx_b.push_back(8'h3C);
    exp_rd_b.push_back(8'h01); exp_tx_b.push_back(8'hC3);
    wait_idle_b();

    // unknown opcode followed directly by a read
    step();
    rxq_a.push_back(8'h00);
    rxq_a.push_back(8'h52); rxq_a.push_back(8'h01);
    exp_tx_a.push_back(8'h3F);
    exp_rd_a.push_back(8'h01);
    exp_tx_a.push_back(8'hC3);
    wait_idle_a();

    // partial frame abandoned after TO_CYC idle cycles
    step();
    rxq_a.push_back(8'h57); rxq_a.push_back(8'h05);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("timeout_still_busy", {31'd0, busy}, 32'd1);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("timeout_back_to_idle", {31'd0, busy}, 32'd0);
    step();
    rxq_a.push_back(8'h57); rxq_a.push_back(8'h06); rxq_a.push_back(8'h77);
    exp_wr_a.push_back(16'h0677);
    exp_tx_a.push_back(8'h4B);
    wait_idle_a();

    // reply held back by a full transmit FIFO
    step();
    transmit_full = 1'b1;
    bw0 = bw_count;
    rxq_a.push_back(8'h52); rxq_a.push_back(8'h22);
    exp_rd_a.push_back(8'h22);
    exp_tx_a.push_back(8'h3C);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("no_push_while_full", bw_count, bw0);
    chk("busy_while_full", {31'd0, busy}, 32'd1);
    step();
    transmit_full = 1'b0;
    wait_idle_a();
    chk("single_push_after_full", bw_count, bw0 + 1);

    // reset in the middle of a frame discards it
    step();
    rxq_a.push_back(8'h57); rxq_a.push_back(8'h33);
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero();
    step();
    reset = 1'b1;
    step();
    rxq_a.push_back(8'h57); rxq_a.push_back(8'h44); rxq_a.push_back(8'h99);
    exp_wr_a.push_back(16'h4499);
    exp_tx_a.push_back(8'h4B);
    wait_idle_a();

    // status opcode (error counter cleared by the reset above)
    step();
    rxq_a.push_back(8'h00); rxq_a.push_back(8'h12); rxq_a.push_back(8'h53);
    exp_tx_a.push_back(8'h3F);
    exp_tx_a.push_back(8'h3F);
`ifdef UART_CMD_STATUS_EN
    exp_tx_a.push_back(8'h02);
`else
    exp_tx_a.push_back(8'h3F);
`endif
    wait_idle_a();
    step();
    rxq_a.push_back(8'h53);
`ifdef UART_CMD_STATUS_EN
    exp_tx_a.push_back(8'h00);
`else
    exp_tx_a.push_back(8'h3F);
`endif
    wait_idle_a();

    // everything expected was observed
    repeat (5) @(negedge clk);
    chk("left_tx_a", exp_tx_a.size(), 32'd0);
    chk("left_wr_a", exp_wr_a.size(), 32'd0);
    chk("left_rd_a", exp_rd_a.size(), 32'd0);
    chk("left_tx_b", exp_tx_b.size(), 32'd0);
    chk("left_rd_b", exp_rd_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
